rom_read_arbiter: RTL and testbench

//  Shares one rom_read-style read port (read_ce/address -> dout/rfin) between instruction fetch (IF) and data load (LD).

---
 rtl/rom_read_arbiter_pkg.sv | 11 +
 rtl/rom_read_arbiter_rr_pick2.sv | 17 +
 rtl/rom_read_arbiter.sv | 127 ++++++++++++
 tb/tb_rom_read_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/rom_read_arbiter_pkg.sv
// rom_read_arbiter_pkg: shared FSM encoding, grant IDs and default timeout
package rom_read_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_LD = 1'b1;
    localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/rom_read_arbiter_rr_pick2.sv
// rr_pick2: 2-way round-robin picker between IF and LD
//   req_if, req_ld  in   pending requests
//   last_grant      in   previous winner (GNT_IF/GNT_LD)
//   grant_valid     out  some request is pending
//   winner          out  chosen requester; on a tie, the one not granted last
module rr_pick2
    import rom_read_arbiter_pkg::*;
(
    input  logic req_if,
    input  logic req_ld,
    input  logic last_grant,
    output logic grant_valid,
    output logic winner
);
    assign grant_valid = req_if | req_ld;
    assign winner = (req_if & req_ld) ? ~last_grant : (req_ld ? GNT_LD : GNT_IF);
endmodule

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: shares one read port between instruction fetch and data load
//   clk, rst            clock, sync active-high reset
//   if_req/if_addr      IF request + byte address; if_rdata/if_valid completion
//   ld_req/ld_addr      LD request + byte address; ld_rdata/ld_valid completion
//   rd_ce/rd_addr       read engine enable + word-aligned address
//   rd_dout/rd_fin      read engine data + done
//   timeout             pulse on forced completion
//   stall               any request still waiting for its valid
module rom_read_arbiter
    import rom_read_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_valid,
    output logic              rd_ce,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_dout,
    input  logic              rd_fin,
    output logic              timeout,
    output logic              stall
);
    localparam logic [7:0] TO = 8'(TIMEOUT);
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              rd_ce_q, rd_ce_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, ld_rdata_q, ld_rdata_d, cap;
    logic              if_valid_q, if_valid_d, ld_valid_q, ld_valid_d;
    logic              timeout_q, timeout_d;
    logic              gnt_valid, winner;

    rr_pick2 u_pick (
        .req_if      (if_req),
        .req_ld      (ld_req),
        .last_grant  (last_q),
        .grant_valid (gnt_valid),
        .winner      (winner)
    );

    // last_q doubles as the owner of the access in flight
    assign cap = rd_fin ? rd_dout : '0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        rd_ce_d    = rd_ce_q;
        rd_addr_d  = rd_addr_q;
        if_rdata_d = if_rdata_q;
        ld_rdata_d = ld_rdata_q;
        if_valid_d = 1'b0;
        ld_valid_d = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: if (gnt_valid) begin
                state_d   = BUSY;
                rd_addr_d = (winner == GNT_LD ? ld_addr : if_addr) & WORD_MASK;
                rd_ce_d   = 1'b1;
                cnt_d     = '0;
                last_d    = winner;
            end
            BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (rd_fin || cnt_q == TO) begin
                    ld_rdata_d = last_q == GNT_LD ? cap : ld_rdata_q;
                    if_rdata_d = last_q == GNT_IF ? cap : if_rdata_q;
                    ld_valid_d = last_q == GNT_LD && ld_req;
                    if_valid_d = last_q == GNT_IF && if_req;
                    timeout_d  = ~rd_fin;
                    rd_ce_d    = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= GNT_IF;
            rd_ce_q    <= 1'b0;
            rd_addr_q  <= '0;
            if_rdata_q <= '0;
            ld_rdata_q <= '0;
            if_valid_q <= 1'b0;
            ld_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            rd_ce_q    <= rd_ce_d;
            rd_addr_q  <= rd_addr_d;
            if_rdata_q <= if_rdata_d;
            ld_rdata_q <= ld_rdata_d;
            if_valid_q <= if_valid_d;
            ld_valid_q <= ld_valid_d;
            timeout_q  <= timeout_d;
        end
    end

    assign rd_ce    = rd_ce_q;
    assign rd_addr  = rd_addr_q;
    assign if_rdata = if_rdata_q;
    assign ld_rdata = ld_rdata_q;
    assign if_valid = if_valid_q;
    assign ld_valid = ld_valid_q;
    assign timeout  = timeout_q;
    assign stall    = (if_req & ~if_valid_q) | (ld_req & ~ld_valid_q);
endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb_rom_read_arbiter: directed + randomized check of rom_read_arbiter against a transaction model
module tb_rom_read_arbiter;
    logic        clk = 1'b0;
    logic        rst, if_req, ld_req, rd_fin;
    logic [31:0] if_addr, ld_addr, rd_dout;
    logic [31:0] if_rdata, ld_rdata, rd_addr;
    logic        if_valid, ld_valid, rd_ce, timeout, stall;
    int          n_assert = 0;
    int          n_fail = 0;
    bit          m_last;
    logic [31:0] m_if, m_ld;

    always #5 clk = ~clk;

    rom_read_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .ld_req   (ld_req),
        .ld_addr  (ld_addr),
        .ld_rdata (ld_rdata),
        .ld_valid (ld_valid),
        .rd_ce    (rd_ce),
        .rd_addr  (rd_addr),
        .rd_dout  (rd_dout),
        .rd_fin   (rd_fin),
        .timeout  (timeout),
        .stall    (stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete access from IDLE: k = edges from grant to completion,
    // fin = engine answers on edge k (else k must be 256 for the timeout),
    // drop = winner withdraws its request right after the grant.
    task automatic access(input bit ifr, input bit ldr, input logic [31:0] ifa, input logic [31:0] lda,
                          input int k, input bit fin, input bit drop, input logic [31:0] data);
        bit          w;
        bit          ev_if, ev_ld;
        logic [31:0] ed;
        if_req = ifr; ld_req = ldr; if_addr = ifa; ld_addr = lda; rd_fin = 1'b0;
        w = (ifr && ldr) ? !m_last : ldr;
        tick();
        chk("grant_ce", rd_ce, 1);
        chk("grant_addr", rd_addr, (w ? lda : ifa) & 32'hFFFF_FFFC);
        chk("busy_stall", stall, ifr | ldr);
        chk("busy_no_valid", {if_valid, ld_valid}, 0);
        if (drop) begin
            if (w) ld_req = 1'b0; else if_req = 1'b0;
        end
        for (int i = 1; i < k; i++) begin
            rd_dout = $urandom;
            tick();
        end
        chk("busy_hold_ce", rd_ce, 1);
        chk("busy_no_to", timeout, 0);
        rd_fin = fin; rd_dout = data;
        tick();
        rd_fin = 1'b0;
        ed = fin ? data : 32'h0;
        m_last = w;
        if (w) m_ld = ed; else m_if = ed;
        ev_if = !w && !drop;
        ev_ld = w && !drop;
        chk("done_ce", rd_ce, 0);
        chk("done_if_valid", if_valid, ev_if);
        chk("done_ld_valid", ld_valid, ev_ld);
        chk("done_if_rdata", if_rdata, m_if);
        chk("done_ld_rdata", ld_rdata, m_ld);
        chk("done_timeout", timeout, !fin);
        chk("done_stall", stall, (if_req & !ev_if) | (ld_req & !ev_ld));
        if (w) ld_req = 1'b0; else if_req = 1'b0;
        tick();
        chk("idle_valid", {if_valid, ld_valid}, 0);
        chk("idle_timeout", timeout, 0);
        chk("idle_ce", rd_ce, 0);
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; ld_req = 1'b0; rd_fin = 1'b0;
        if_addr = '0; ld_addr = '0; rd_dout = '0;
        m_last = 1'b0; m_if = '0; m_ld = '0;
        tick();
        tick();
        chk("rst_outputs", {rd_ce, if_valid, ld_valid, timeout, stall}, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rdata", {if_rdata, ld_rdata}, 0);
        rst = 1'b0;
        tick();

        // single IF access, misaligned address
        access(1, 0, 32'h0000_0107, 32'h0, 4, 1, 0, 32'h2402_0001);
        chk("single_if_addr_ld_untouched", ld_rdata, 0);

        // tie after reset is still won by LD since last grant was IF
        access(1, 1, 32'h0000_1000, 32'h0000_2002, 2, 1, 0, 32'hAAAA_0001);
        access(1, 0, 32'h0000_1000, 32'h0, 3, 1, 0, 32'hBBBB_0002);
        access(1, 1, 32'h0000_3001, 32'h0000_4003, 1, 1, 0, 32'hCCCC_0003);
        access(1, 0, 32'h0000_3001, 32'h0, 1, 1, 0, 32'hDDDD_0004);

        // forced completion, then the coincident fin/timeout edge
        access(0, 1, 32'h0, 32'h0000_0ABC, 256, 0, 0, 32'hDEAD_BEEF);
        access(0, 1, 32'h0, 32'h0000_0AB0, 256, 1, 0, 32'h1234_5678);

        // withdrawn request still completes without a valid pulse
        access(1, 0, 32'h0000_5555, 32'h0, 3, 1, 1, 32'h5A5A_A5A5);

        // rd_fin while idle changes nothing
        rd_fin = 1'b1; rd_dout = 32'hFFFF_FFFF;
        tick();
        tick();
        chk("idle_fin_ce", rd_ce, 0);
        chk("idle_fin_valid", {if_valid, ld_valid, timeout}, 0);
        chk("idle_fin_rdata", {if_rdata, ld_rdata}, {m_if, m_ld});
        rd_fin = 1'b0;

        // reset in the middle of an access
        if_req = 1'b1; if_addr = 32'h0000_0200;
        tick();
        tick();
        tick();
        chk("pre_rst_busy", rd_ce, 1);
        rst = 1'b1; rd_fin = 1'b1; rd_dout = 32'h7777_7777;
        tick();
        chk("mid_rst_ce", rd_ce, 0);
        chk("mid_rst_valid", {if_valid, ld_valid, timeout}, 0);
        chk("mid_rst_rdata", {if_rdata, ld_rdata}, 0);
        rst = 1'b0; rd_fin = 1'b0;
        m_last = 1'b0; m_if = '0; m_ld = '0;
        access(1, 0, 32'h0000_0200, 32'h0, 2, 1, 0, 32'h0BAD_F00D);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            bit ifr, ldr;
            ifr = 1'($urandom_range(0, 1));
            ldr = ifr ? 1'($urandom_range(0, 1)) : 1'b1;
            access(ifr, ldr, $urandom, $urandom, $urandom_range(1, 6), 1,
                   $urandom_range(0, 7) == 0, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
